// File: rtl/prim_assembler.sv
// prim_assembler
//   Consumer end of the decode stage's primitive stream. Decode cannot be
//   stalled, so every Start/Draw/End event is buffered in a small FIFO. The
//   read side groups the buffered vertices into points, lines, triangles or
//   strip triangles. Each finished primitive goes to the rasterizer over a
//   valid/ready handshake.
// Ports
//   CLOCK_50, Reset         : rising-edge clock, synchronous active-high reset
//   StartPrimitive, PrimitiveType, Draw, Vertex, EndPrimitive : decode events
//   prim_ready / prim_valid : rasterizer handshake
//   prim_type, prim_v0..v2, prim_nverts : emitted primitive (unused slots are 0)
//   fifo_full               : input FIFO full (combinational)
//   overflow, proto_err     : sticky error flags, cleared only by Reset
module prim_assembler #(
    parameter int VERT_W  = 32,
    parameter int FIFO_AW = 3
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic              StartPrimitive,
    input  logic [3:0]        PrimitiveType,
    input  logic              Draw,
    input  logic [VERT_W-1:0] Vertex,
    input  logic              EndPrimitive,
    input  logic              prim_ready,
    output logic              prim_valid,
    output logic [3:0]        prim_type,
    output logic [VERT_W-1:0] prim_v0,
    output logic [VERT_W-1:0] prim_v1,
    output logic [VERT_W-1:0] prim_v2,
    output logic [1:0]        prim_nverts,
    output logic              fifo_full,
    output logic              overflow,
    output logic              proto_err
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int ENT_W = VERT_W + 7;

    localparam logic [3:0] T_POINTS = 4'd0;
    localparam logic [3:0] T_LINES  = 4'd1;
    localparam logic [3:0] T_TRIS   = 4'd2;
    localparam logic [3:0] T_STRIP  = 4'd3;

    typedef enum logic {IDLE, OPEN} state_e;

    // ---------------- input FIFO ----------------
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               full, empty, push_req, push, pop;
    logic               e_end, e_start, e_draw;
    logic [3:0]         e_type;
    logic [VERT_W-1:0]  e_vert;

    // ---------------- assembly state ----------------
    state_e             state_q, state_d;
    logic [3:0]         type_q, type_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               par_q, par_d;       // parity of n, keeps strip winding once cnt saturates
    logic [VERT_W-1:0]  hist0_q, hist0_d;   // v[n-2]
    logic [VERT_W-1:0]  hist1_q, hist1_d;   // v[n-1]
    logic               emit, perr_set;
    logic [VERT_W-1:0]  ev0, ev1, ev2;
    logic [1:0]         en;

    // ---------------- output register ----------------
    logic               pv_q, pv_d;
    logic [3:0]         pt_q, pt_d;
    logic [VERT_W-1:0]  v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic [1:0]         nv_q, nv_d;
    logic               ovf_q, ovf_d, perr_q, perr_d;

    always_comb begin
        // An extra MSB on each pointer separates full from empty.
        full     = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        push_req = StartPrimitive | Draw | EndPrimitive;
        // Fullness is judged before this cycle's pop, so a push into a full
        // FIFO is dropped even if a pop happens at the same edge.
        push     = push_req && !full;
        pop      = !empty && (!pv_q || prim_ready);
        wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
        {e_end, e_start, e_draw, e_type, e_vert} = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    end

    // Sub-events of one entry are applied in order: end, start, draw.
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        hist0_d  = hist0_q;
        hist1_d  = hist1_q;
        emit     = 1'b0;
        perr_set = 1'b0;
        ev0      = '0;
        ev1      = '0;
        ev2      = '0;
        en       = 2'd0;
        if (pop) begin
            if (e_end) state_d = IDLE;
            if (e_start) begin
                if (state_d == OPEN) perr_set = 1'b1;   // implicit end
                if (e_type > T_STRIP) perr_set = 1'b1;  // its draws get dropped below
                state_d = OPEN;
                type_d  = e_type;
                cnt_d   = 2'd0;
                par_d   = 1'b0;
                hist0_d = '0;
                hist1_d = '0;
            end
            if (e_draw) begin
                if (state_d == IDLE) begin
                    perr_set = 1'b1;
                end else if (type_d <= T_STRIP) begin
                    ev2 = e_vert;
                    case (type_d)
                        T_POINTS: begin
                            emit = 1'b1;
                            ev0  = e_vert;
                            ev2  = '0;
                            en   = 2'd1;
                        end
                        T_LINES: begin
                            ev2 = '0;
                            if (cnt_d == 2'd1) begin
                                emit  = 1'b1;
                                ev0   = hist1_d;
                                ev1   = e_vert;
                                en    = 2'd2;
                                cnt_d = 2'd0;
                            end else begin
                                cnt_d = 2'd1;
                            end
                        end
                        T_TRIS: begin
                            if (cnt_d == 2'd2) begin
                                emit  = 1'b1;
                                ev0   = hist0_d;
                                ev1   = hist1_d;
                                en    = 2'd3;
                                cnt_d = 2'd0;
                            end else begin
                                cnt_d = cnt_d + 2'd1;
                            end
                        end
                        default: begin  // T_STRIP
                            if (cnt_d >= 2'd2) begin
                                emit = 1'b1;
                                ev0  = par_d ? hist1_d : hist0_d;
                                ev1  = par_d ? hist0_d : hist1_d;
                                en   = 2'd3;
                            end
                            if (cnt_d != 2'd3) cnt_d = cnt_d + 2'd1;
                        end
                    endcase
                    if (!emit) ev2 = '0;
                    hist0_d = hist1_d;
                    hist1_d = e_vert;
                    par_d   = ~par_d;
                end
            end
        end
    end

    always_comb begin
        pv_d = pv_q;
        pt_d = pt_q;
        v0_d = v0_q;
        v1_d = v1_q;
        v2_d = v2_q;
        nv_d = nv_q;
        // emit only happens on a pop, which implies the register is free.
        if (emit) begin
            pv_d = 1'b1;
            pt_d = type_d;
            v0_d = ev0;
            v1_d = ev1;
            v2_d = ev2;
            nv_d = en;
        end else if (prim_ready) begin
            pv_d = 1'b0;
        end
        ovf_d  = ovf_q | (push_req & full);
        perr_d = perr_q | perr_set;
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {EndPrimitive, StartPrimitive, Draw, PrimitiveType, Vertex};
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= IDLE;
            type_q   <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            hist0_q  <= '0;
            hist1_q  <= '0;
            pv_q     <= 1'b0;
            pt_q     <= '0;
            v0_q     <= '0;
            v1_q     <= '0;
            v2_q     <= '0;
            nv_q     <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            type_q   <= type_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            hist0_q  <= hist0_d;
            hist1_q  <= hist1_d;
            pv_q     <= pv_d;
            pt_q     <= pt_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            nv_q     <= nv_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
        end
    end

    assign prim_valid  = pv_q;
    assign prim_type   = pt_q;
    assign prim_v0     = v0_q;
    assign prim_v1     = v1_q;
    assign prim_v2     = v2_q;
    assign prim_nverts = nv_q;
    assign fifo_full   = full;
    assign overflow    = ovf_q;
    assign proto_err   = perr_q;
endmodule
